// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multicycle core control unit.
//   ctrl_state_t : controller phase encoding (FETCH .. HALT)
//   OP_*         : instr[15:12] opcode values
//   ALUOP_*      : alu_op codes handed to the ALU control decoder
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } ctrl_state_t;

    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_LSL  = 4'b0101;
    localparam logic [3:0] OP_LSR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNQ  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_UND0 = 4'b1101;
    localparam logic [3:0] OP_UND1 = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALUOP_ADDR = 2'b10;
    localparam logic [1:0] ALUOP_CMP  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b00;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control unit for the 16-bit RISC core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives datapath enables.
// Ports:
//   clk, rst_n (sync, active-low)       clock / reset
//   instr[15:0], zero, mem_ready        IR contents, ALU zero flag, memory handshake
//   ir_write, pc_write, pc_src[1:0]     IR / PC load controls
//   alu_src_a, alu_src_b[1:0], alu_op   ALU operand and operation select
//   opcode[3:0]                         instr[15:12] for the ALU decoder (0 in FETCH/HALT)
//   mem_read, mem_write, iord           memory request and address select
//   reg_write, mem_to_reg               register file write controls
//   halted                              high in HALT
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int INSTRW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INSTRW-1:0] instr,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [OPW-1:0]    opcode,
    output logic              mem_read,
    output logic              mem_write,
    output logic              iord,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              halted
);

    ctrl_state_t state_q, state_d;
    logic [OPW-1:0] op;
    logic           unused_instr_bits;

    assign op = instr[INSTRW-1 -: OPW];
    // Low instruction bits (immediates, register fields) feed the datapath directly.
    assign unused_instr_bits = ^instr[INSTRW-OPW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_FUNC;
        opcode     = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        // Reset masks every output so a pending memory write cannot issue.
        if (!rst_n) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_ONE;
                    alu_op    = ALUOP_ADDR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    opcode    = op;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADDR;
                    case (op)
                        OP_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = PCSRC_JMP;
                            state_d  = FETCH;
                        end
                        OP_HALT:          state_d = HALT;
                        OP_UND0, OP_UND1: state_d = FETCH;
                        default:          state_d = EXECUTE;
                    endcase
                end
                EXECUTE: begin
                    opcode    = op;
                    alu_src_a = 1'b1;
                    if (op == OP_LW || op == OP_SW) begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_ADDR;
                        state_d   = MEM;
                    end else if (op == OP_BEQ || op == OP_BNQ) begin
                        alu_op   = ALUOP_CMP;
                        pc_src   = PCSRC_BR;
                        pc_write = (op == OP_BEQ) ? zero : !zero;
                        state_d  = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
                MEM: begin
                    opcode    = op;
                    iord      = 1'b1;
                    mem_read  = (op == OP_LW);
                    mem_write = (op != OP_LW);
                    if (mem_ready) state_d = (op == OP_LW) ? WRITEBACK : FETCH;
                end
                WRITEBACK: begin
                    opcode     = op;
                    reg_write  = 1'b1;
                    mem_to_reg = (op == OP_LW);
                    state_d    = FETCH;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        ir_write, pc_write, alu_src_a, mem_read, mem_write;
    logic        iord, reg_write, mem_to_reg, halted;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [3:0]  opcode;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPW(4), .INSTRW(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] opcode;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic rst_n;
        logic ready;
        logic zero;
        ctl_t exp;
    } step_t;

    ctl_t sb[$];

    function automatic ctl_t observed();
        ctl_t c;
        c = '{ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, opcode,
              mem_read, mem_write, iord, reg_write, mem_to_reg, halted};
        return c;
    endfunction

    // Expected control words, written straight from the phase descriptions.
    function automatic ctl_t x_zero();
        ctl_t c = '0;
        return c;
    endfunction
    function automatic ctl_t x_fetch(logic rdy);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
        c.ir_write = rdy;  c.pc_write = rdy;
        return c;
    endfunction
    function automatic ctl_t x_dec(logic [3:0] op);
        ctl_t c = '0;
        c.opcode = op; c.alu_src_b = 2'b10; c.alu_op = 2'b10;
        if (op == 4'hC) begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
        return c;
    endfunction
    function automatic ctl_t x_exe(logic [3:0] op, logic z);
        ctl_t c = '0;
        c.opcode = op; c.alu_src_a = 1'b1;
        if (op <= 4'h1) begin
            c.alu_src_b = 2'b10; c.alu_op = 2'b10;
        end else if (op == 4'hA || op == 4'hB) begin
            c.alu_op = 2'b01; c.pc_src = 2'b01;
            c.pc_write = (op == 4'hA) ? z : ~z;
        end
        return c;
    endfunction
    function automatic ctl_t x_mem(logic [3:0] op);
        ctl_t c = '0;
        c.opcode = op; c.iord = 1'b1;
        if (op == 4'h0) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        return c;
    endfunction
    function automatic ctl_t x_wb(logic [3:0] op);
        ctl_t c = '0;
        c.opcode = op; c.reg_write = 1'b1; c.mem_to_reg = (op == 4'h0);
        return c;
    endfunction
    function automatic ctl_t x_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction
    function automatic step_t st(logic r, logic rdy, logic z, ctl_t e);
        step_t s;
        s.rst_n = r; s.ready = rdy; s.zero = z; s.exp = e;
        return s;
    endfunction

    // Each task runs from a negedge; inputs change there and outputs are sampled 1ns later.
    task automatic test_reset();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'h2123;
        for (int i = 0; i < 3; i++) s.push_back(st(1'b0, 1'b1, 1'b0, x_zero()));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_add();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'h2123;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,0,x_dec(4'h2)), st(1,1,0,x_exe(4'h2,0)),
              st(1,1,0,x_wb(4'h2)), st(1,0,0,x_fetch(0)), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL add[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'h0124;
        s = '{st(1,1,0,x_fetch(1)), st(1,0,0,x_dec(4'h0)), st(1,0,0,x_exe(4'h0,0)),
              st(1,0,0,x_mem(4'h0)), st(1,0,0,x_mem(4'h0)), st(1,1,0,x_mem(4'h0)),
              st(1,1,0,x_wb(4'h0)), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL lw[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [15:0] br [2] = '{16'hA105, 16'hB105};
        step_t s[$];
        ctl_t  want, got;
        for (int b = 0; b < 2; b++) begin
            for (int z = 0; z < 2; z++) begin
                logic [3:0] op = br[b][15:12];
                instr = br[b];
                s = '{st(1,1,z[0],x_fetch(1)), st(1,1,z[0],x_dec(op)),
                      st(1,1,z[0],x_exe(op,z[0])), st(1,0,z[0],x_fetch(0))};
                foreach (s[i]) begin
                    rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
                    sb.push_back(s[i].exp);
                    #1;
                    got = observed(); want = sb.pop_front(); total++;
                    if (got !== want)
                        $display("FAIL br_%h_z%0d[%0d] got=%h want=%h", br[b], z, i, got, want);
                    else passed++;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_jmp_sw();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'hC0FF;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,0,x_dec(4'hC)), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL jmp[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
        instr = 16'h1124;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,0,x_dec(4'h1)), st(1,1,0,x_exe(4'h1,0)),
              st(1,1,0,x_mem(4'h1)), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL sw[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'hF000;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,0,x_dec(4'hF))};
        for (int i = 0; i < 20; i++) s.push_back(st(1, i[0], i[1], x_halt()));
        s.push_back(st(0,1,0,x_zero()));
        s.push_back(st(1,0,0,x_fetch(0)));
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL halt[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_and_illegal();
        step_t s[$];
        ctl_t  want, got;
        instr = 16'h1124;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,0,x_dec(4'h1)), st(1,0,0,x_exe(4'h1,0)),
              st(1,0,0,x_mem(4'h1)), st(0,0,0,x_zero()), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL rst_mid[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
        instr = 16'hD000;
        s = '{st(1,1,0,x_fetch(1)), st(1,1,1,x_dec(4'hD)), st(1,0,0,x_fetch(0))};
        foreach (s[i]) begin
            rst_n = s[i].rst_n; mem_ready = s[i].ready; zero = s[i].zero;
            sb.push_back(s[i].exp);
            #1;
            got = observed(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL illegal[%0d] got=%h want=%h", i, got, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jmp_sw();
        test_halt();
        test_reset_mid_and_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
